// File: rtl/iv_merge_unit.sv
// iv_merge_unit: places a masked, right-justified field into an 8-bit IV-bus byte
// using read-modify-write (merge) or a direct full-byte write; busy stalls upstream.
// Optional `IV_MERGE_FWD_EN forwards the last written byte so a merge to the same address skips RD.
module iv_merge_unit #(
  parameter int ACK_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_hazard,
  input  logic       op_valid,
  input  logic       merge_en,
  input  logic [7:0] masked_in,
  input  logic [2:0] L_select,
  input  logic [2:0] pos_select,
  input  logic [7:0] iv_addr_in,
  output logic       iv_rd_req,
  output logic       iv_wr_req,
  output logic [7:0] iv_addr,
  output logic [7:0] iv_wr_data,
  input  logic [7:0] iv_rd_data,
  input  logic       iv_ack,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  // The last missed-ack cycle is the one that makes the count reach ACK_TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       field_q, field_d;
  logic [2:0]       len_q, len_d;
  logic [2:0]       pos_q, pos_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

`ifdef IV_MERGE_FWD_EN
  logic             fwd_vld_q, fwd_vld_d;
  logic [7:0]       fwd_addr_q, fwd_addr_d;
  logic [7:0]       fwd_data_q, fwd_data_d;
  logic             fwd_hit;
  assign fwd_hit = fwd_vld_q && (fwd_addr_q == iv_addr_in);
`endif

  // Merge a field into a byte: length 0 means a full 8-bit field; bits pushed past bit 7 are lost.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] fld,
                                            input logic [2:0] len, input logic [2:0] pos);
    logic [7:0] fmask;
    logic [7:0] pm;
    fmask = (len == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - {1'b0, len}));
    pm    = fmask << pos;
    return (old_b & ~pm) | ((fld << pos) & pm);
  endfunction

  // Next-state and datapath: acceptance in IDLE, ack/timeout handling in RD and WR.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    field_d   = field_q;
    len_d     = len_q;
    pos_d     = pos_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef IV_MERGE_FWD_EN
    fwd_vld_d  = fwd_vld_q;
    fwd_addr_d = fwd_addr_q;
    fwd_data_d = fwd_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (op_valid && !data_hazard) begin
          addr_d  = iv_addr_in;
          field_d = masked_in;
          len_d   = L_select;
          pos_d   = pos_select;
          tmo_d   = '0;
          if (merge_en) begin
`ifdef IV_MERGE_FWD_EN
            if (fwd_hit) begin
              wr_data_d = merge_byte(fwd_data_q, masked_in, L_select, pos_select);
              state_d   = WR;
            end else begin
              state_d = RD;
            end
`else
            state_d = RD;
`endif
          end else begin
            wr_data_d = masked_in;
            state_d   = WR;
`ifdef IV_MERGE_FWD_EN
            if (fwd_addr_q != iv_addr_in) fwd_vld_d = 1'b0;
`endif
          end
        end
      end
      RD: begin
        if (iv_ack) begin
          wr_data_d = merge_byte(iv_rd_data, field_q, len_q, pos_q);
          tmo_d     = '0;
          state_d   = WR;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
`ifdef IV_MERGE_FWD_EN
          fwd_vld_d = 1'b0;
`endif
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WR: begin
        if (iv_ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef IV_MERGE_FWD_EN
          fwd_vld_d  = 1'b1;
          fwd_addr_d = addr_q;
          fwd_data_d = wr_data_q;
`endif
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
`ifdef IV_MERGE_FWD_EN
          fwd_vld_d = 1'b0;
`endif
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      addr_q    <= '0;
      field_q   <= '0;
      len_q     <= '0;
      pos_q     <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      field_q   <= field_d;
      len_q     <= len_d;
      pos_q     <= pos_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef IV_MERGE_FWD_EN
  // Forwarded copy of the last completed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_vld_q  <= fwd_vld_d;
      fwd_addr_q <= fwd_addr_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`endif

  // Requests decode straight from state so an async reset drops them at once.
  assign iv_rd_req  = (state_q == RD);
  assign iv_wr_req  = (state_q == WR);
  assign busy       = (state_q != IDLE);
  assign iv_addr    = addr_q;
  assign iv_wr_data = wr_data_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_iv_merge_unit.sv
// Randomized bench for iv_merge_unit with a bus responder and an arithmetic reference model.
module tb_iv_merge_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_hazard = 1'b0;
  logic       op_valid = 1'b0;
  logic       merge_en = 1'b0;
  logic [7:0] masked_in = '0;
  logic [2:0] L_select = '0;
  logic [2:0] pos_select = '0;
  logic [7:0] iv_addr_in = '0;
  logic       iv_rd_req, iv_wr_req, busy, done, err;
  logic [7:0] iv_addr, iv_wr_data;
  logic [7:0] iv_rd_data = '0;
  logic       iv_ack = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  iv_merge_unit #(.ACK_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .data_hazard(data_hazard), .op_valid(op_valid),
    .merge_en(merge_en), .masked_in(masked_in), .L_select(L_select),
    .pos_select(pos_select), .iv_addr_in(iv_addr_in), .iv_rd_req(iv_rd_req),
    .iv_wr_req(iv_wr_req), .iv_addr(iv_addr), .iv_wr_data(iv_wr_data),
    .iv_rd_data(iv_rd_data), .iv_ack(iv_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: field of width len (0 -> 8) placed at pos, anything past bit 7 discarded.
  function automatic int ref_merge(int old_b, int fld, int len, int pos);
    int width, pm;
    width = (len == 0) ? 8 : len;
    pm    = (((1 << width) - 1) << pos) % 256;
    return (old_b & (255 - pm)) | (((fld << pos) % 256) & pm);
  endfunction

  // One transaction; rdd/wrd = wait cycles before ack (>= 15 means never ack).
  task automatic run_op(input string nm, input int mrg, input int fld, input int len,
                        input int pos, input int addr, input int old_b,
                        input int rdd, input int wrd);
    int ev, evc, saw_rd, saw_wr, wdat, rd_n, wr_n, both, addr_bad, busy_end;
    int exp_ev, exp_c, exp_wr, s;
    ev = 0; evc = 0; saw_rd = 0; saw_wr = 0; wdat = -1; rd_n = 0; wr_n = 0;
    both = 0; addr_bad = 0; busy_end = -1;
    @(negedge clk);
    merge_en   = mrg[0];
    masked_in  = fld[7:0];
    L_select   = len[2:0];
    pos_select = pos[2:0];
    iv_addr_in = addr[7:0];
    data_hazard = 1'b0;
    op_valid   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      data_hazard = 1'($urandom_range(0, 1));
      if (done || err) begin
        ev = done ? 1 : 2;
        evc = c;
        busy_end = int'(busy);
        break;
      end
      if (iv_rd_req && iv_wr_req) both++;
      if ((iv_rd_req || iv_wr_req) && iv_addr != addr[7:0]) addr_bad++;
      if (iv_rd_req) begin
        saw_rd = 1;
        iv_ack = (rd_n == rdd);
        iv_rd_data = iv_ack ? old_b[7:0] : 8'($urandom);
        rd_n++;
      end else if (iv_wr_req) begin
        saw_wr = 1;
        wdat = int'(iv_wr_data);
        iv_ack = (wr_n == wrd);
        wr_n++;
      end else begin
        iv_ack = 1'b0;
      end
    end
    op_valid = 1'b0;
    iv_ack = 1'b0;
    data_hazard = 1'b0;
    // Expected outcome from the cycle-level protocol description.
    exp_wr = 1;
    if (mrg != 0 && rdd >= 15) begin
      exp_ev = 2; exp_c = 16; exp_wr = 0;
    end else begin
      s = (mrg != 0) ? rdd + 2 : 1;
      if (wrd >= 15) begin exp_ev = 2; exp_c = s + 15; end
      else begin exp_ev = 1; exp_c = s + wrd + 1; end
    end
    chk({nm, ".event"}, ev, exp_ev);
    chk({nm, ".cycle"}, evc, exp_c);
    chk({nm, ".rdreq"}, saw_rd, mrg != 0 ? 1 : 0);
    chk({nm, ".wrreq"}, saw_wr, exp_wr);
    if (exp_wr != 0)
      chk({nm, ".wdata"}, wdat, (mrg != 0) ? ref_merge(old_b, fld, len, pos) : fld);
    chk({nm, ".addr"}, addr_bad, 0);
    chk({nm, ".excl"}, both, 0);
    chk({nm, ".busy_end"}, busy_end, 0);
  endtask

  initial begin
    int bad, mrg, rdd, wrd;
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.rdreq", int'(iv_rd_req), 0);
    chk("rst.wrreq", int'(iv_wr_req), 0);
    chk("rst.done_err", int'({done, err}), 0);
    chk("rst.addr", int'(iv_addr), 0);
    chk("rst.wdata", int'(iv_wr_data), 0);
    rst = 1'b0;

    run_op("merge_basic", 1, 'h05, 3, 2, 'h10, 'hFF, 0, 0);
    chk("merge_basic.model", ref_merge('hFF, 'h05, 3, 2), 'hF7);
    run_op("merge_full",  1, 'hA5, 0, 0, 'h11, 'h3C, 0, 0);
    run_op("truncate",    1, 'h0F, 4, 6, 'h12, 'h00, 0, 0);
    chk("truncate.model", ref_merge('h00, 'h0F, 4, 6), 'hC0);
    run_op("direct",      0, 'h5A, 5, 3, 'h22, 'h00, 0, 0);
    run_op("rd_timeout",  1, 'h33, 2, 1, 'h30, 'h55, 15, 0);
    run_op("rd_ack_last", 1, 'h33, 2, 1, 'h31, 'h55, 14, 2);
    run_op("wr_timeout",  0, 'h77, 0, 0, 'h32, 'h00, 0, 15);
    run_op("wr_ack_last", 1, 'hC3, 6, 1, 'h33, 'h81, 1, 14);

    // Hazard in IDLE blocks acceptance; a stray ack in IDLE does nothing.
    bad = 0;
    @(negedge clk);
    data_hazard = 1'b1; op_valid = 1'b1; merge_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv_ack = (i == 1);
      @(negedge clk);
      if (busy || iv_rd_req || iv_wr_req || done || err) bad++;
    end
    op_valid = 1'b0; data_hazard = 1'b0; iv_ack = 1'b0;
    chk("hazard_idle", bad, 0);

    // Async reset while reading drops the request without waiting for a clock edge.
    @(negedge clk);
    merge_en = 1'b1; masked_in = 8'h0F; iv_addr_in = 8'h40; op_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid.rdreq_before", int'(iv_rd_req), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.rdreq", int'(iv_rd_req), 0);
    chk("rstmid.busy", int'(busy), 0);
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || err || busy) bad++;
    end
    chk("rstmid.quiet", bad, 0);

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      mrg = int'($urandom_range(0, 1));
      rdd = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      wrd = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      run_op($sformatf("rnd%0d", k), mrg, int'($urandom_range(0, 255)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rdd, wrd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iv_merge_unit.md
Name: iv_merge_unit

Overview:
- Stage directly downstream of the mask stage in the CPU datapath.
- Takes the masked, right-justified field from the mask stage and places it at a bit position in an 8-bit destination on the IV bus.
- Performs an IV-bus read-modify-write: read the destination byte, merge the field in, write the byte back. A direct full-byte write is also supported.
- Asserts busy while a transaction is in flight so the sequencer can stall the mask stage.

Parameters:
- ACK_TIMEOUT, 15: maximum cycles to wait for iv_ack in a bus state before aborting.
- TMO_W, 4: width of the timeout counter; must satisfy 2^TMO_W > ACK_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_hazard  in  1  upstream stall; while high, no new op is accepted.
- op_valid  in  1  operation request from the mask stage.
- merge_en  in  1  1 = read-modify-write merge; 0 = direct full-byte write.
- masked_in  in  8  masked field from the mask stage (mask_out).
- L_select  in  3  field length; 0 means 8 bits.
- pos_select  in  3  bit position of the field LSB in the destination.
- iv_addr_in  in  8  destination IV address.
- iv_rd_req  out  1  IV read request; held until acknowledged.
- iv_wr_req  out  1  IV write request; held until acknowledged.
- iv_addr  out  8  registered IV address.
- iv_wr_data  out  8  registered write data.
- iv_rd_data  in  8  read data, valid when iv_ack is high in state RD.
- iv_ack  in  1  bus acknowledge, one cycle per request.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after a completed write.
- err  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset: state IDLE; all outputs 0; internal registers 0.
- Reset is asynchronous: asserting rst mid-transaction drops iv_rd_req and iv_wr_req in the same cycle and abandons the op. No done or err pulse is produced.
- States: IDLE, RD, WR.
- Acceptance: on a rising edge with state=IDLE, op_valid=1 and data_hazard=0, register masked_in, L_select, pos_select, iv_addr_in and merge_en. Then go to RD if merge_en=1, else WR.
- op_valid is ignored when not in IDLE or when data_hazard=1. Upstream must hold the op until busy falls.
- Field mask: fmask = 8'hFF if L=0, else (1<<L)-1.
- Placement: pm = (fmask<<pos)[7:0]. Bits shifted above bit 7 are discarded; there is no wrap-around.
- RD: iv_rd_req=1. On an edge with iv_ack=1:
  - iv_wr_data <= (iv_rd_data & ~pm) | ((masked_in<<pos)[7:0] & pm);
  - state goes to WR.
- Direct write (merge_en=0): iv_wr_data is loaded with masked_in unchanged at acceptance; pos and L are ignored.
- WR: iv_wr_req=1. On an edge with iv_ack=1: state goes to IDLE and done=1 for the following cycle.
- Latency with zero-wait ack: merge takes 1 cycle RD plus 1 cycle WR, with done in cycle 3 after acceptance. Direct write has done in cycle 2.
- Timeout: the counter clears on entry to RD or WR and increments each cycle without ack.
  - When the count reaches ACK_TIMEOUT: state goes to IDLE, requests drop, err=1 for one cycle, and no write occurs.
  - An ack arriving in the same cycle the count reaches ACK_TIMEOUT wins: normal progression, no err.
- iv_ack in IDLE is ignored.
- iv_rd_req and iv_wr_req are never high together.
- iv_addr is stable from acceptance until the return to IDLE.
- data_hazard has no effect once a transaction has been accepted.

Optional Feature:
- Macro: IV_MERGE_FWD_EN.
- Defined: keep a valid copy of the last written address and data.
- If an accepted merge op targets the same address as the previous completed write, skip RD. The merge uses the forwarded byte and the op goes IDLE to WR, finishing 1 cycle earlier.
- The forwarded copy is invalidated by reset, by err, and by any direct write to a different address. A direct write refreshes the copy.
- Undefined: every merge op performs RD; no forwarding registers exist.

Test Plan:
- Merge, zero-wait ack: masked_in=0x05, L=3, pos=2, addr=0x10, iv_rd_data=0xFF -> read then write of 0xF7 to 0x10; done in cycle 3; busy high cycles 1-2.
- Full-byte merge: L=0, pos=0, masked_in=0xA5, read 0x3C -> write 0xA5.
- Truncation: L=4, pos=6, masked_in=0x0F, read 0x00 -> write 0xC0; bits above bit 7 dropped.
- Direct write: merge_en=0, masked_in=0x5A, addr=0x22 -> no iv_rd_req; iv_wr_req in cycle 1 with data 0x5A; done in cycle 2.
- Timeout and stall: ACK_TIMEOUT=15, no ack in RD -> err pulse after 15 cycles, requests low, busy low, no write. A second op_valid presented while busy (or with data_hazard=1 in IDLE) is not accepted.
- Reset mid-RD: assert rst while iv_rd_req=1 -> iv_rd_req=0 in the same cycle, no done/err. With IV_MERGE_FWD_EN: back-to-back merges to 0x10 -> second op issues no iv_rd_req.
